// File: rtl/fc_psum_accum.sv
// Partial-sum accumulator behind the FC PE array: sums acc_len floating-point
// psums per output neuron, applies optional ReLU and hands the result over valid/ready.

module fp_adder2 #(
    parameter int EXPONENT = 8,
    parameter int MANTISSA = 23
) (
    input  logic [EXPONENT+MANTISSA:0] i_a,
    input  logic [EXPONENT+MANTISSA:0] i_b,
    output logic [EXPONENT+MANTISSA:0] o_sum
);
    localparam int W  = 1 + EXPONENT + MANTISSA;
    // carry + hidden + mantissa + guard/round/sticky
    localparam int FW = MANTISSA + 5;
    localparam int EW = EXPONENT + 2;
    localparam logic [EXPONENT-1:0]        EMAX    = '1;
    localparam logic signed [EW-1:0]       EXP_MAX = EW'((2 ** EXPONENT) - 1);
    localparam logic signed [EW-1:0]       EXP_ONE = EW'(1);

    logic [W-1:0]              w_big, w_sml;
    logic                      w_s_big, w_s_sml;
    logic [EXPONENT-1:0]       w_e_big, w_e_sml, w_diff;
    logic [FW-1:0]             w_m_big, w_m_sml, w_m_al, w_m_sum, w_m_nrm;
    logic                      w_sticky, w_rnd_up;
    logic signed [EW-1:0]      w_exp;
    logic [MANTISSA+1:0]       w_m_rnd;

    always_comb begin
        if (i_a[W-2:0] >= i_b[W-2:0]) begin
            w_big = i_a;
            w_sml = i_b;
        end else begin
            w_big = i_b;
            w_sml = i_a;
        end
        w_s_big = w_big[W-1];
        w_s_sml = w_sml[W-1];
        w_e_big = w_big[W-2:MANTISSA];
        w_e_sml = w_sml[W-2:MANTISSA];
        // Subnormal inputs are flushed to zero by masking their mantissa.
        w_m_big = {1'b0, |w_e_big, w_big[MANTISSA-1:0] & {MANTISSA{|w_e_big}}, 3'b000};
        w_m_sml = {1'b0, |w_e_sml, w_sml[MANTISSA-1:0] & {MANTISSA{|w_e_sml}}, 3'b000};
        w_diff  = w_e_big - w_e_sml;

        w_m_al   = w_m_sml;
        w_sticky = 1'b0;
        for (int i = 0; i < FW; i++) begin
            if (i < int'(w_diff)) begin
                w_sticky = w_sticky | w_m_al[0];
                w_m_al   = w_m_al >> 1;
            end
        end
        w_m_al[0] = w_m_al[0] | w_sticky;

        if (w_s_big == w_s_sml) begin
            w_m_sum = w_m_big + w_m_al;
        end else begin
            w_m_sum = w_m_big - w_m_al;
        end

        w_exp   = $signed({2'b00, w_e_big});
        w_m_nrm = w_m_sum;
        if (w_m_nrm[FW-1]) begin
            w_m_nrm = {1'b0, w_m_sum[FW-1:2], w_m_sum[1] | w_m_sum[0]};
            w_exp   = w_exp + EXP_ONE;
        end else begin
            for (int i = 0; i < FW - 1; i++) begin
                if (!w_m_nrm[FW-2] && (w_m_nrm != '0)) begin
                    w_m_nrm = w_m_nrm << 1;
                    w_exp   = w_exp - EXP_ONE;
                end
            end
        end

        // Round to nearest, ties to even.
        w_rnd_up = w_m_nrm[2] & (w_m_nrm[1] | w_m_nrm[0] | w_m_nrm[3]);
        w_m_rnd  = {1'b0, w_m_nrm[FW-2:3]} + {{(MANTISSA+1){1'b0}}, w_rnd_up};
        if (w_m_rnd[MANTISSA+1]) begin
            w_m_rnd = w_m_rnd >> 1;
            w_exp   = w_exp + EXP_ONE;
        end

        if (w_e_big == EMAX) begin
            if ((w_e_sml == EMAX) && (w_s_big != w_s_sml)) begin
                o_sum = {1'b0, EMAX, 1'b1, {(MANTISSA-1){1'b0}}};
            end else begin
                o_sum = w_big;
            end
        end else if (w_m_sum == '0) begin
            o_sum = {w_s_big & w_s_sml, {(W-1){1'b0}}};
        end else if (w_exp >= EXP_MAX) begin
            o_sum = {w_s_big, EMAX, {MANTISSA{1'b0}}};
        end else if (w_exp < EXP_ONE) begin
            o_sum = {w_s_big, {(W-1){1'b0}}};
        end else begin
            o_sum = {w_s_big, w_exp[EXPONENT-1:0], w_m_rnd[MANTISSA-1:0]};
        end
    end
endmodule

module fc_psum_accum #(
    parameter int EXPONENT  = 8,
    parameter int MANTISSA  = 23,
    parameter int ACC_CNT_W = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ACC_CNT_W-1:0]        acc_len_i,
    input  logic                        acc_relu_i,
    input  logic                        acc_clear_i,
    input  logic                        psum_valid_i,
    input  logic [EXPONENT+MANTISSA:0]  psum_i,
    output logic                        psum_ready_o,
    output logic                        acc_valid_o,
    output logic [EXPONENT+MANTISSA:0]  acc_data_o,
    input  logic                        acc_ready_i,
    output logic                        acc_busy_o
);
    localparam int W = 1 + EXPONENT + MANTISSA;
    localparam logic [ACC_CNT_W-1:0] CNT_ONE = ACC_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_HOLD
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [ACC_CNT_W-1:0]   r_cnt, r_len, w_len_eff, w_cnt_inc;
    logic                   r_relu;
    logic [W-1:0]           r_acc, w_sum;
    logic [W-1:0]           r_data_p1;
    logic                   r_vld_p1;
    logic                   w_ready, w_start, w_add, w_out_xfer;

    function automatic logic [W-1:0] relu_fn(input logic [W-1:0] x, input logic en);
        return (en && x[W-1]) ? '0 : x;
    endfunction

    fp_adder2 #(
        .EXPONENT (EXPONENT),
        .MANTISSA (MANTISSA)
    ) u_add (
        .i_a   (r_acc),
        .i_b   (psum_i),
        .o_sum (w_sum)
    );

    assign w_len_eff = (acc_len_i == '0) ? CNT_ONE : acc_len_i;
    assign w_cnt_inc = r_cnt + CNT_ONE;

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_start     = 1'b0;
        w_add       = 1'b0;
        w_out_xfer  = r_vld_p1 & acc_ready_i;
        if (acc_clear_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_ready = 1'b1;
                    w_start = psum_valid_i;
                end
                S_ACCUM: begin
                    w_ready = 1'b1;
                    w_add   = psum_valid_i;
                    if (psum_valid_i && (w_cnt_inc == r_len)) begin
                        w_state_nxt = S_HOLD;
                    end
                end
                S_HOLD: begin
                    // A new group may start in the same cycle the result leaves.
                    w_ready = acc_ready_i;
                    w_start = psum_valid_i & acc_ready_i;
                    if (w_out_xfer) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
            if (w_start) begin
                w_state_nxt = (w_len_eff == CNT_ONE) ? S_HOLD : S_ACCUM;
            end
        end
    end

    // Stage p1: finished sum registered once on the way into HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_len     <= '0;
            r_relu    <= 1'b0;
            r_acc     <= '0;
            r_data_p1 <= '0;
            r_vld_p1  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (acc_clear_i) begin
                r_vld_p1 <= 1'b0;
                r_cnt    <= '0;
                r_acc    <= '0;
            end else if (w_start) begin
                r_acc    <= psum_i;
                r_cnt    <= CNT_ONE;
                r_len    <= w_len_eff;
                r_relu   <= acc_relu_i;
                r_vld_p1 <= (w_len_eff == CNT_ONE);
                if (w_len_eff == CNT_ONE) begin
                    r_data_p1 <= relu_fn(psum_i, acc_relu_i);
                end
            end else if (w_add) begin
                r_acc <= w_sum;
                r_cnt <= w_cnt_inc;
                if (w_cnt_inc == r_len) begin
                    r_data_p1 <= relu_fn(w_sum, r_relu);
                    r_vld_p1  <= 1'b1;
                end
            end else if (w_out_xfer) begin
                r_vld_p1 <= 1'b0;
            end
        end
    end

    assign psum_ready_o = w_ready;
    assign acc_valid_o  = r_vld_p1;
    assign acc_data_o   = r_data_p1;
    assign acc_busy_o   = (r_state != S_IDLE);
endmodule

// File: tb/tb_fc_psum_accum.sv
// Bench for fc_psum_accum: directed vector table, handshake corner sequences,
// and randomized groups checked against an integer-arithmetic reference.

module tb_fc_psum_accum;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [9:0]    acc_len_i = '0;
    logic          acc_relu_i = 1'b0;
    logic          acc_clear_i = 1'b0;
    logic          psum_valid_i = 1'b0;
    logic [W-1:0]  psum_i = '0;
    logic          psum_ready_o;
    logic          acc_valid_o;
    logic [W-1:0]  acc_data_o;
    logic          acc_ready_i = 1'b0;
    logic          acc_busy_o;

    int checks   = 0;
    int failures = 0;

    fc_psum_accum dut (
        .clk          (clk),
        .rst          (rst),
        .acc_len_i    (acc_len_i),
        .acc_relu_i   (acc_relu_i),
        .acc_clear_i  (acc_clear_i),
        .psum_valid_i (psum_valid_i),
        .psum_i       (psum_i),
        .psum_ready_o (psum_ready_o),
        .acc_valid_o  (acc_valid_o),
        .acc_data_o   (acc_data_o),
        .acc_ready_i  (acc_ready_i),
        .acc_busy_o   (acc_busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0]       len;
        logic             relu;
        logic [2:0]       n;
        logic [3:0][31:0] p;
        logic [31:0]      expv;
    } vec_t;

    typedef struct packed {
        logic [9:0]  len;
        logic        relu;
        logic [31:0] val;
    } stim_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Exact integer -> single-precision conversion, |v| < 2^24.
    function automatic logic [31:0] int2fp(input int v);
        int mag;
        int e;
        logic [31:0] r;
        if (v == 0) return 32'h0;
        mag = (v < 0) ? -v : v;
        e = 0;
        for (int k = 0; k < 24; k++) if (mag >= (1 << k)) e = k;
        r[31]    = (v < 0);
        r[30:23] = 8'(127 + e);
        r[22:0]  = 23'(mag << (23 - e));
        return r;
    endfunction

    function automatic vec_t mk(input int len, input bit relu, input int n,
                                input logic [31:0] p0, input logic [31:0] p1,
                                input logic [31:0] p2, input logic [31:0] p3,
                                input logic [31:0] expv);
        vec_t v;
        v.len  = 10'(len);
        v.relu = relu;
        v.n    = 3'(n);
        v.p[0] = p0;
        v.p[1] = p1;
        v.p[2] = p2;
        v.p[3] = p3;
        v.expv = expv;
        return v;
    endfunction

    task automatic run_group(input logic [9:0] len, input logic relu, input int n,
                             input logic [3:0][31:0] p, input logic [31:0] expv);
        acc_len_i   = len;
        acc_relu_i  = relu;
        acc_ready_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            psum_valid_i = 1'b1;
            psum_i       = p[i];
            tick();
            if (i < n - 1) check("grp_mid_valid", 32'(acc_valid_o), 32'd0);
        end
        psum_valid_i = 1'b0;
        #1;
        check("grp_valid", 32'(acc_valid_o), 32'd1);
        check("grp_data", acc_data_o, expv);
        check("grp_hold_ready", 32'(psum_ready_o), 32'd0);
        acc_ready_i = 1'b1;
        tick();
        acc_ready_i = 1'b0;
        #1;
        check("grp_done_valid", 32'(acc_valid_o), 32'd0);
        check("grp_done_busy", 32'(acc_busy_o), 32'd0);
    endtask

    vec_t  vecs[12];
    stim_t stim[$];
    logic [31:0] exp_q[$];

    initial begin
        vecs[0]  = mk(3, 0, 3, 32'h3F800000, 32'h40000000, 32'h40400000, 0, 32'h40C00000);
        vecs[1]  = mk(2, 1, 2, 32'h3F800000, 32'hC0400000, 0, 0, 32'h00000000);
        vecs[2]  = mk(2, 0, 2, 32'h3F800000, 32'hC0400000, 0, 0, 32'hC0000000);
        vecs[3]  = mk(0, 0, 1, 32'h40A00000, 0, 0, 0, 32'h40A00000);
        vecs[4]  = mk(1, 1, 1, 32'h40A00000, 0, 0, 0, 32'h40A00000);
        vecs[5]  = mk(1, 1, 1, 32'h80000000, 0, 0, 0, 32'h00000000);
        vecs[6]  = mk(1, 0, 1, 32'h80000000, 0, 0, 0, 32'h80000000);
        vecs[7]  = mk(2, 0, 2, 32'h3FC00000, 32'hBFC00000, 0, 0, 32'h00000000);
        vecs[8]  = mk(2, 0, 2, 32'h4B800000, 32'h3F800000, 0, 0, 32'h4B800000);
        vecs[9]  = mk(2, 0, 2, 32'h4B800000, 32'h40000000, 0, 0, 32'h4B800001);
        vecs[10] = mk(4, 0, 4, 32'h3F000000, 32'h3E800000, 32'h3E800000, 32'h3F800000, 32'h40000000);
        vecs[11] = mk(2, 1, 2, 32'hC0000000, 32'h40A00000, 0, 0, 32'h40400000);

        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_valid", 32'(acc_valid_o), 32'd0);
        check("rst_data", acc_data_o, 32'd0);
        check("rst_busy", 32'(acc_busy_o), 32'd0);
        check("idle_ready", 32'(psum_ready_o), 32'd1);

        for (int i = 0; i < 12; i++) begin
            run_group(vecs[i].len, vecs[i].relu, int'(vecs[i].n), vecs[i].p, vecs[i].expv);
        end

        // One result per cycle with len=1 and the consumer always ready.
        acc_len_i = 10'd1; acc_relu_i = 1'b0; acc_ready_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            psum_valid_i = 1'b1;
            psum_i = int2fp(k);
            tick();
            check("thru_valid", 32'(acc_valid_o), 32'd1);
            check("thru_data", acc_data_o, int2fp(k));
        end
        psum_valid_i = 1'b0;
        tick();
        check("thru_end_valid", 32'(acc_valid_o), 32'd0);
        acc_ready_i = 1'b0;

        // Stalled consumer, then same-cycle handoff into the next group.
        acc_len_i = 10'd2;
        psum_valid_i = 1'b1; psum_i = 32'h3F800000; tick();
        psum_i = 32'h40000000; tick();
        psum_i = 32'h40800000;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("stall_valid", 32'(acc_valid_o), 32'd1);
            check("stall_data", acc_data_o, 32'h40400000);
            check("stall_ready", 32'(psum_ready_o), 32'd0);
            tick();
        end
        acc_ready_i = 1'b1;
        #1;
        check("handoff_ready", 32'(psum_ready_o), 32'd1);
        tick();
        acc_ready_i = 1'b0;
        psum_i = 32'h40A00000;
        #1;
        check("handoff_valid", 32'(acc_valid_o), 32'd0);
        check("handoff_busy", 32'(acc_busy_o), 32'd1);
        tick();
        psum_valid_i = 1'b0;
        #1;
        check("handoff_res_valid", 32'(acc_valid_o), 32'd1);
        check("handoff_res_data", acc_data_o, 32'h41100000);
        acc_ready_i = 1'b1; tick(); acc_ready_i = 1'b0;

        // Abort mid-group.
        acc_len_i = 10'd4;
        psum_valid_i = 1'b1; psum_i = 32'h3F800000; tick();
        psum_i = 32'h40000000; tick();
        acc_clear_i = 1'b1; psum_i = 32'h40E00000;
        #1;
        check("clear_ready", 32'(psum_ready_o), 32'd0);
        tick();
        acc_clear_i = 1'b0; psum_valid_i = 1'b0;
        #1;
        check("clear_valid", 32'(acc_valid_o), 32'd0);
        check("clear_busy", 32'(acc_busy_o), 32'd0);
        run_group(10'd2, 1'b0, 2, {32'h0, 32'h0, 32'h40000000, 32'h40000000}, 32'h40800000);

        // Reset in ACCUM, then in HOLD.
        acc_len_i = 10'd3;
        psum_valid_i = 1'b1; psum_i = 32'h3F800000; tick();
        psum_valid_i = 1'b0; rst = 1'b1; tick();
        rst = 1'b0; #1;
        check("rst_accum_busy", 32'(acc_busy_o), 32'd0);
        check("rst_accum_valid", 32'(acc_valid_o), 32'd0);
        acc_len_i = 10'd1;
        psum_valid_i = 1'b1; psum_i = 32'h40A00000; tick();
        psum_valid_i = 1'b0; #1;
        check("pre_rst_hold_valid", 32'(acc_valid_o), 32'd1);
        rst = 1'b1; tick();
        rst = 1'b0; #1;
        check("rst_hold_valid", 32'(acc_valid_o), 32'd0);
        check("rst_hold_data", acc_data_o, 32'd0);
        check("rst_hold_busy", 32'(acc_busy_o), 32'd0);

        // Random groups with bubbles on both sides.
        for (int g = 0; g < 40; g++) begin
            int len, n, sum, v;
            bit relu;
            len  = int'($urandom_range(0, 6));
            relu = 1'($urandom_range(0, 1));
            n    = (len == 0) ? 1 : len;
            sum  = 0;
            for (int j = 0; j < n; j++) begin
                stim_t s;
                v = int'($urandom_range(0, 1000)) - 500;
                sum += v;
                s.len = 10'(len);
                s.relu = relu;
                s.val = int2fp(v);
                stim.push_back(s);
            end
            exp_q.push_back(int2fp((relu && sum < 0) ? 0 : sum));
        end
        begin
            int idx, cyc;
            idx = 0;
            cyc = 0;
            tick();
            while ((idx < stim.size() || exp_q.size() > 0) && cyc < 5000) begin
                if (idx < stim.size()) begin
                    psum_valid_i = ($urandom_range(0, 3) != 0);
                    acc_len_i    = stim[idx].len;
                    acc_relu_i   = stim[idx].relu;
                    psum_i       = stim[idx].val;
                end else begin
                    psum_valid_i = 1'b0;
                    psum_i       = $urandom;
                end
                acc_ready_i = ($urandom_range(0, 2) != 0);
                #1;
                if (acc_valid_o && acc_ready_i) begin
                    if (exp_q.size() == 0) check("rnd_extra_result", 32'(acc_valid_o), 32'd0);
                    else check("rnd_data", acc_data_o, exp_q.pop_front());
                end
                if (psum_valid_i && psum_ready_o) idx++;
                tick();
                cyc++;
            end
            psum_valid_i = 1'b0;
            acc_ready_i  = 1'b0;
            check("rnd_all_results", 32'(exp_q.size()), 32'd0);
            check("rnd_all_psums", 32'(idx), 32'(stim.size()));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
